mc_control_fsm: RTL and testbench

- Control unit for the multi-cycle RV32I core. It sits directly upstream of the datapath muxes, ALU, register file and shared instruction/data memory, and drives every select and enable those consume.
- Main decoder is a Moore FSM stepping each instruction through Fetch/Decode/Execute/Memory/Writeback.
- Combinational ALU decoder and immediate-type decoder are included.
- Decodes opcodes LW, I_TYPE_ALU, SW, R_TYPE_ALU, B_TYPE (beq/bne) and JAL, using the pa_riscv encodings.

---
 rtl/mc_control_fsm.sv | 272 +++++++++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multi-cycle RV32I control unit (optional MC_ILLEGAL_TRAP_EN adds TRAP state)
package pa_riscv;

    typedef enum logic [6:0] {
        OP_LW         = 7'b0000011,
        OP_I_TYPE_ALU = 7'b0010011,
        OP_SW         = 7'b0100011,
        OP_R_TYPE_ALU = 7'b0110011,
        OP_B_TYPE     = 7'b1100011,
        OP_JAL        = 7'b1101111
    } ty_OPERAND;

    typedef enum logic [1:0] {
        WD_ALU_OUTPUT_REG = 2'b00,
        WD_DATA_REG       = 2'b01,
        WD_ALU_RESULT     = 2'b10
    } ty_INPUT_TO_WRITEDATA;

    typedef enum logic [1:0] {
        SRCA_PC     = 2'b00,
        SRCA_OLD_PC = 2'b01,
        SRCA_RD1    = 2'b10
    } ty_ALU_SRC_A;

    typedef enum logic [1:0] {
        SRCB_RD2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } ty_ALU_SRC_B;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } ty_IMM_SRC;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SLT = 4'b0010,
        ALU_XOR = 4'b0100,
        ALU_OR  = 4'b0110,
        ALU_AND = 4'b0111,
        ALU_SUB = 4'b1000
    } ty_ALU_OP;

endpackage

module mc_control_fsm
    import pa_riscv::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_zero,
    output logic       o_pcWrite,
    output logic       o_adrSrc,
    output logic       o_memWrite,
    output logic       o_irWrite,
    output logic       o_regWrite,
    output logic [1:0] o_resultSrc,
    output logic [1:0] o_aluSrcA,
    output logic [1:0] o_aluSrcB,
    output logic [3:0] o_aluControl,
    output logic [1:0] o_immSrc,
`ifdef MC_ILLEGAL_TRAP_EN
    output logic       o_illegalInstr,
`endif
    output logic       o_instrDone
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_JAL      = 4'd8,
        S_ALUWB    = 4'd9,
        S_BRANCH   = 4'd10,
        S_TRAP     = 4'd11
    } ty_STATE;

    ty_STATE    r_state;
    ty_STATE    w_next_state;

    logic       w_pc_update;
    logic       w_branch;
    logic       w_adr_src;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic [1:0] w_result_src;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [3:0] w_alu_control;
    logic [1:0] w_imm_src;
    logic       w_instr_done;
`ifdef MC_ILLEGAL_TRAP_EN
    logic       w_illegal;
`endif

    // Only the ALU operations the datapath implements pass through; anything else collapses to ADD.
    function automatic logic [3:0] f_alu_decode(input logic [3:0] code);
        case (code)
            ALU_SUB, ALU_SLT, ALU_XOR, ALU_OR, ALU_AND: f_alu_decode = code;
            default:                                   f_alu_decode = ALU_ADD;
        endcase
    endfunction

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and Moore outputs per state.
    always_comb begin
        w_next_state  = S_FETCH;
        w_pc_update   = 1'b0;
        w_branch      = 1'b0;
        w_adr_src     = 1'b0;
        w_mem_write   = 1'b0;
        w_ir_write    = 1'b0;
        w_reg_write   = 1'b0;
        w_result_src  = WD_ALU_OUTPUT_REG;
        w_alu_src_a   = SRCA_PC;
        w_alu_src_b   = SRCB_RD2;
        w_alu_control = ALU_ADD;
        w_instr_done  = 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
        w_illegal     = 1'b0;
`endif
        case (r_state)
            S_FETCH: begin
                w_ir_write   = 1'b1;
                w_alu_src_a  = SRCA_PC;
                w_alu_src_b  = SRCB_FOUR;
                w_result_src = WD_ALU_RESULT;
                w_pc_update  = 1'b1;
                w_next_state = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is computed here so BRANCH can load it from the ALU output register.
                w_alu_src_a = SRCA_OLD_PC;
                w_alu_src_b = SRCB_IMM;
                case (i_opcode)
                    OP_LW, OP_SW:  w_next_state = S_MEMADR;
                    OP_R_TYPE_ALU: w_next_state = S_EXECUTER;
                    OP_I_TYPE_ALU: w_next_state = S_EXECUTEI;
                    OP_JAL:        w_next_state = S_JAL;
                    OP_B_TYPE:     w_next_state = S_BRANCH;
                    default: begin
`ifdef MC_ILLEGAL_TRAP_EN
                        w_next_state = S_TRAP;
`else
                        w_instr_done = 1'b1;
                        w_next_state = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a  = SRCA_RD1;
                w_alu_src_b  = SRCB_IMM;
                w_next_state = (i_opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_adr_src    = 1'b1;
                w_result_src = WD_ALU_OUTPUT_REG;
                w_next_state = S_MEMWB;
            end
            S_MEMWB: begin
                w_result_src = WD_DATA_REG;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                w_adr_src    = 1'b1;
                w_result_src = WD_ALU_OUTPUT_REG;
                w_mem_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next_state = S_FETCH;
            end
            S_EXECUTER: begin
                w_alu_src_a   = SRCA_RD1;
                w_alu_src_b   = SRCB_RD2;
                w_alu_control = f_alu_decode({i_funct7b5, i_funct3});
                w_next_state  = S_ALUWB;
            end
            S_EXECUTEI: begin
                // instr[30] is part of the immediate for I-type, so it never selects SUB.
                w_alu_src_a   = SRCA_RD1;
                w_alu_src_b   = SRCB_IMM;
                w_alu_control = f_alu_decode({1'b0, i_funct3});
                w_next_state  = S_ALUWB;
            end
            S_JAL: begin
                w_alu_src_a  = SRCA_OLD_PC;
                w_alu_src_b  = SRCB_FOUR;
                w_result_src = WD_ALU_OUTPUT_REG;
                w_pc_update  = 1'b1;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                w_result_src = WD_ALU_OUTPUT_REG;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next_state = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_src_a   = SRCA_RD1;
                w_alu_src_b   = SRCB_RD2;
                w_alu_control = ALU_SUB;
                w_result_src  = WD_ALU_OUTPUT_REG;
                w_branch      = 1'b1;
                w_instr_done  = 1'b1;
                w_next_state  = S_FETCH;
            end
            S_TRAP: begin
`ifdef MC_ILLEGAL_TRAP_EN
                w_illegal    = 1'b1;
                w_next_state = S_TRAP;
`else
                w_next_state = S_FETCH;
`endif
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    // Immediate format follows the opcode directly so it is valid from DECODE onwards.
    always_comb begin
        w_imm_src = IMM_I;
        case (i_opcode)
            OP_SW:     w_imm_src = IMM_S;
            OP_B_TYPE: w_imm_src = IMM_B;
            OP_JAL:    w_imm_src = IMM_J;
            default:   w_imm_src = IMM_I;
        endcase
    end

    // While reset is low every strobe and select is held at zero, regardless of state.
    always_comb begin
        o_pcWrite    = i_rst_n & (w_pc_update | (w_branch & (i_zero ^ i_funct3[0])));
        o_adrSrc     = i_rst_n & w_adr_src;
        o_memWrite   = i_rst_n & w_mem_write;
        o_irWrite    = i_rst_n & w_ir_write;
        o_regWrite   = i_rst_n & w_reg_write;
        o_instrDone  = i_rst_n & w_instr_done;
        o_resultSrc  = i_rst_n ? w_result_src  : 2'b00;
        o_aluSrcA    = i_rst_n ? w_alu_src_a   : 2'b00;
        o_aluSrcB    = i_rst_n ? w_alu_src_b   : 2'b00;
        o_aluControl = i_rst_n ? w_alu_control : ALU_ADD;
        o_immSrc     = i_rst_n ? w_imm_src     : 2'b00;
`ifdef MC_ILLEGAL_TRAP_EN
        o_illegalInstr = i_rst_n & w_illegal;
`endif
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - randomized self-checking bench for mc_control_fsm
module tb_mc_control_fsm;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic [6:0] i_opcode;
    logic [2:0] i_funct3;
    logic       i_funct7b5;
    logic       i_zero;
    logic       o_pcWrite, o_adrSrc, o_memWrite, o_irWrite, o_regWrite, o_instrDone;
    logic [1:0] o_resultSrc, o_aluSrcA, o_aluSrcB, o_immSrc;
    logic [3:0] o_aluControl;
`ifdef MC_ILLEGAL_TRAP_EN
    logic       o_illegalInstr;
`endif

    int checks = 0;
    int errors = 0;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_JAL = 4, K_B = 5, K_ILL = 6;

    mc_control_fsm dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_opcode(i_opcode), .i_funct3(i_funct3),
        .i_funct7b5(i_funct7b5), .i_zero(i_zero),
        .o_pcWrite(o_pcWrite), .o_adrSrc(o_adrSrc), .o_memWrite(o_memWrite),
        .o_irWrite(o_irWrite), .o_regWrite(o_regWrite), .o_resultSrc(o_resultSrc),
        .o_aluSrcA(o_aluSrcA), .o_aluSrcB(o_aluSrcB), .o_aluControl(o_aluControl),
        .o_immSrc(o_immSrc),
`ifdef MC_ILLEGAL_TRAP_EN
        .o_illegalInstr(o_illegalInstr),
`endif
        .o_instrDone(o_instrDone)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [17:0] observed();
        return {o_pcWrite, o_adrSrc, o_memWrite, o_irWrite, o_regWrite, o_resultSrc,
                o_aluSrcA, o_aluSrcB, o_aluControl, o_immSrc, o_instrDone};
    endfunction

    function automatic logic [6:0] opcode_of(int kind);
        logic [6:0] ill [3];
        ill[0] = 7'h7f; ill[1] = 7'h37; ill[2] = 7'h00;
        case (kind)
            K_LW:    return 7'b0000011;
            K_SW:    return 7'b0100011;
            K_R:     return 7'b0110011;
            K_I:     return 7'b0010011;
            K_JAL:   return 7'b1101111;
            K_B:     return 7'b1100011;
            default: return ill[$urandom_range(0, 2)];
        endcase
    endfunction

    function automatic int length_of(int kind);
        case (kind)
            K_LW:    return 5;
            K_SW, K_R, K_I, K_JAL: return 4;
            K_B:     return 3;
            default: return 2;
        endcase
    endfunction

    // ALU ops the core supports: add, sub, slt, xor, or, and; everything else must come out as add.
    function automatic logic [3:0] alu_ref(logic [3:0] code);
        return (code inside {4'b0000, 4'b1000, 4'b0010, 4'b0100, 4'b0110, 4'b0111}) ? code : 4'b0000;
    endfunction

    // Expected control word for cycle c (0 = fetch) of an instruction of the given kind.
    function automatic logic [17:0] expect_vec(int kind, int c, logic [2:0] f3, logic f7, logic z);
        logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0, dn = 0;
        logic [1:0] rs = 0, sa = 0, sb = 0, imm;
        logic [3:0] ac = 0;
        int last = length_of(kind) - 1;
        imm = (kind == K_SW) ? 2'b01 : (kind == K_B) ? 2'b10 : (kind == K_JAL) ? 2'b11 : 2'b00;
        if (c == 0) begin
            irw = 1; pcw = 1; sb = 2'b10; rs = 2'b10;
        end else if (c == 1) begin
            sa = 2'b01; sb = 2'b01; dn = (kind == K_ILL);
        end else begin
            dn = (c == last);
            case (kind)
                K_LW: if (c == 2) begin sa = 2'b10; sb = 2'b01; end
                      else if (c == 3) adr = 1;
                      else begin rs = 2'b01; rw = 1; end
                K_SW: if (c == 2) begin sa = 2'b10; sb = 2'b01; end
                      else begin adr = 1; mw = 1; end
                K_R:  if (c == 2) begin sa = 2'b10; ac = alu_ref({f7, f3}); end
                      else rw = 1;
                K_I:  if (c == 2) begin sa = 2'b10; sb = 2'b01; ac = alu_ref({1'b0, f3}); end
                      else rw = 1;
                K_JAL: if (c == 2) begin sa = 2'b01; sb = 2'b10; pcw = 1; end
                       else rw = 1;
                K_B:  begin sa = 2'b10; ac = 4'b1000; pcw = z ^ f3[0]; end
                default: ;
            endcase
        end
        return {pcw, adr, mw, irw, rw, rs, sa, sb, ac, imm, dn};
    endfunction

    task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Runs one instruction; zmode 0/1 forces i_zero, 2 randomizes it; rst_at >= 0 asserts reset in that cycle.
    task automatic run_instr(input int kind, input logic [2:0] f3, input logic f7,
                             input int zmode, input int rst_at);
        logic [17:0] exp;
        i_opcode   = opcode_of(kind);
        i_funct3   = f3;
        i_funct7b5 = f7;
        for (int c = 0; c < length_of(kind); c++) begin
            i_zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            if (c == rst_at) i_rst_n = 1'b0;
            @(negedge i_clk);
            exp = (c == rst_at) ? 18'd0 : expect_vec(kind, c, f3, f7, i_zero);
            check($sformatf("k%0d_c%0d_f3%0d_f7%0d", kind, c, f3, f7), observed(), exp);
`ifdef MC_ILLEGAL_TRAP_EN
            check($sformatf("illegal_k%0d_c%0d", kind, c), {17'd0, o_illegalInstr}, 18'd0);
`endif
            @(posedge i_clk);
            #1;
            if (c == rst_at) begin
                i_rst_n = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int nk;
        i_rst_n    = 1'b0;
        i_opcode   = 7'b0100011;
        i_funct3   = 3'b001;
        i_funct7b5 = 1'b1;
        i_zero     = 1'b1;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check("reset_outputs", observed(), 18'd0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;

        run_instr(K_LW,  3'b010, 1'b0, 2, -1);
        run_instr(K_SW,  3'b010, 1'b0, 2, -1);
        run_instr(K_R,   3'b000, 1'b1, 2, -1);
        run_instr(K_I,   3'b000, 1'b1, 2, -1);
        run_instr(K_B,   3'b000, 1'b0, 1, -1);
        run_instr(K_B,   3'b000, 1'b0, 0, -1);
        run_instr(K_B,   3'b001, 1'b0, 1, -1);
        run_instr(K_B,   3'b001, 1'b0, 0, -1);
        run_instr(K_JAL, 3'b000, 1'b0, 2, -1);
        run_instr(K_R,   3'b001, 1'b0, 2, -1);
        run_instr(K_SW,  3'b010, 1'b0, 2, 3);
        run_instr(K_LW,  3'b010, 1'b0, 2, 2);
`ifndef MC_ILLEGAL_TRAP_EN
        run_instr(K_ILL, 3'b000, 1'b0, 2, -1);
        nk = 6;
`else
        nk = 5;
`endif
        for (int n = 0; n < 200; n++) begin
            run_instr($urandom_range(0, nk), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      2, ($urandom_range(0, 19) == 0) ? $urandom_range(0, 4) : -1);
        end

`ifdef MC_ILLEGAL_TRAP_EN
        i_opcode = 7'h7f;
        @(negedge i_clk);
        check("trap_fetch", observed(), expect_vec(K_ILL, 0, 3'b000, 1'b0, i_zero));
        @(posedge i_clk);
        #1;
        @(negedge i_clk);
        check("trap_decode", observed(), {expect_vec(K_ILL, 1, 3'b000, 1'b0, i_zero)[17:1], 1'b0});
        for (int t = 0; t < 5; t++) begin
            @(posedge i_clk);
            #1;
            @(negedge i_clk);
            check($sformatf("trap_hold_%0d", t), observed(), 18'd0);
            check($sformatf("trap_flag_%0d", t), {17'd0, o_illegalInstr}, 18'd1);
        end
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        run_instr(K_LW, 3'b010, 1'b0, 2, -1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
